// File: rtl/bss_pkg.sv
// Shared BSS framing constants, special-character test, framer state encoding
// and the escape-split record used by the body and checksum paths.
package bss_pkg;

  localparam logic [7:0] STX        = 8'h02;
  localparam logic [7:0] ETX        = 8'h03;
  localparam logic [7:0] ACK        = 8'h06;
  localparam logic [7:0] NAK        = 8'h15;
  localparam logic [7:0] ESC        = 8'h1B;
  localparam logic [7:0] ESC_OFFSET = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STX      = 3'd1,
    ST_BODY     = 3'd2,
    ST_ESC2     = 3'd3,
    ST_CHK      = 3'd4,
    ST_CHK_ESC2 = 3'd5,
    ST_ETX      = 3'd6
  } bss_state_e;

  typedef struct packed {
    logic [7:0] first;
    logic       needs_second;
    logic [7:0] second;
  } esc_split_t;

  function automatic logic is_special(input logic [7:0] b);
    logic special;
    case (b)
      STX, ETX, ACK, NAK, ESC: special = 1'b1;
      default:                 special = 1'b0;
    endcase
    return special;
  endfunction

endpackage

// File: rtl/bss_byte_escaper.sv
// Splits one byte into its wire form: either the byte itself, or ESC followed
// by the byte offset by 0x80 when it collides with a control character.
module bss_byte_escaper
  import bss_pkg::*;
(
  input  logic [7:0] raw_i,
  output esc_split_t split_o
);

  // Escape decision and substituted second byte.
  always_comb begin
    split_o.first        = raw_i;
    split_o.needs_second = 1'b0;
    split_o.second       = 8'h00;
    if (is_special(raw_i)) begin
      split_o.first        = ESC;
      split_o.needs_second = 1'b1;
      split_o.second       = raw_i + ESC_OFFSET;
    end else begin
      split_o.first        = raw_i;
    end
  end

endmodule

// File: rtl/bss_packet_framer.sv
// Walks the body through the upstream byte mux and emits STX, escaped body,
// escaped XOR checksum and ETX as a registered valid/ready byte stream.
module bss_packet_framer
  import bss_pkg::*;
#(
  parameter int PACKET_LEN = 29,
  parameter int SEL_WIDTH  = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [SEL_WIDTH-1:0] data_selector,
  input  logic [7:0]           data,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready
);

  localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(PACKET_LEN - 1);
  localparam logic [SEL_WIDTH-1:0] SEL_ONE  = SEL_WIDTH'(1);

  bss_state_e           state_q, state_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [7:0]           chk_q, chk_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [7:0]           pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic                 last_q, last_d;

  esc_split_t           body_split_s;
  esc_split_t           chk_split_s;
  logic                 hs_s;
  logic                 fetch_s;

  bss_byte_escaper u_body_esc (
    .raw_i   (data),
    .split_o (body_split_s)
  );

  bss_byte_escaper u_chk_esc (
    .raw_i   (chk_q),
    .split_o (chk_split_s)
  );

  assign hs_s = tx_valid_q & tx_ready;

  // Next-state and datapath decisions; fetch_s marks a handshake that pulls the next body byte.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    sel_d      = sel_q;
    chk_d      = chk_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    last_d     = last_q;
    fetch_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_STX;
          tx_data_d  = STX;
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
          chk_d      = 8'h00;
          sel_d      = '0;
          pend_vld_d = 1'b0;
          last_d     = 1'b0;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_STX: begin
        if (hs_s) begin
          state_d = ST_BODY;
          fetch_s = 1'b1;
        end else begin
          state_d = ST_STX;
        end
      end
      ST_BODY: begin
        if (!hs_s) begin
          state_d    = ST_BODY;
        end else if (pend_vld_q) begin
          state_d    = ST_ESC2;
          tx_data_d  = pend_q;
          pend_vld_d = 1'b0;
        end else if (last_q) begin
          state_d    = ST_CHK;
          tx_data_d  = chk_split_s.first;
        end else begin
          state_d    = ST_BODY;
          fetch_s    = 1'b1;
        end
      end
      ST_ESC2: begin
        if (!hs_s) begin
          state_d   = ST_ESC2;
        end else if (last_q) begin
          state_d   = ST_CHK;
          tx_data_d = chk_split_s.first;
        end else begin
          state_d   = ST_BODY;
          fetch_s   = 1'b1;
        end
      end
      ST_CHK: begin
        if (!hs_s) begin
          state_d   = ST_CHK;
        end else if (chk_split_s.needs_second) begin
          state_d   = ST_CHK_ESC2;
          tx_data_d = chk_split_s.second;
        end else begin
          state_d   = ST_ETX;
          tx_data_d = ETX;
          sel_d     = '0;
        end
      end
      ST_CHK_ESC2: begin
        if (hs_s) begin
          state_d   = ST_ETX;
          tx_data_d = ETX;
          sel_d     = '0;
        end else begin
          state_d   = ST_CHK_ESC2;
        end
      end
      ST_ETX: begin
        if (hs_s) begin
          state_d    = ST_IDLE;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          state_d    = ST_ETX;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase

    // The selector parks on the last index so it never points past the body.
    if (fetch_s) begin
      tx_data_d  = body_split_s.first;
      pend_d     = body_split_s.second;
      pend_vld_d = body_split_s.needs_second;
      chk_d      = chk_q ^ data;
      last_d     = (sel_q == LAST_SEL);
      sel_d      = (sel_q == LAST_SEL) ? sel_q : sel_q + SEL_ONE;
    end else begin
      pend_d     = pend_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      sel_q      <= '0;
      chk_q      <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pend_q     <= 8'h00;
      pend_vld_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      sel_q      <= sel_d;
      chk_q      <= chk_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      last_q     <= last_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_valid      = tx_valid_q;
  assign data_selector = sel_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_bss_packet_framer.sv
// Directed bench for bss_packet_framer: plain, body-escape, checksum-escape,
// backpressure and mid-frame start/reset frames.
`timescale 1ns/1ps
module tb_bss_packet_framer;

  localparam int PACKET_LEN = 29;
  localparam int SEL_WIDTH  = 6;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 tx_ready = 1'b0;
  logic                 busy, done, tx_valid;
  logic [SEL_WIDTH-1:0] data_selector;
  logic [7:0]           data, tx_data;

  logic [7:0] body_mem [0:63];
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int done_seen, max_sel, stall_bad, frame_cycles;
  bit etx_seen;

  assign data = body_mem[data_selector];

  always #5 clk = ~clk;

  bss_packet_framer #(.PACKET_LEN(PACKET_LEN), .SEL_WIDTH(SEL_WIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .data_selector (data_selector),
    .data          (data),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_esc(input logic [7:0] b);
    if (b == 8'h02 || b == 8'h03 || b == 8'h06 || b == 8'h15 || b == 8'h1B) begin
      exp_q.push_back(8'h1B);
      exp_q.push_back(b + 8'h80);
    end else begin
      exp_q.push_back(b);
    end
  endtask

  task automatic build_expected();
    logic [7:0] c;
    c = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'h02);
    for (int i = 0; i < PACKET_LEN; i++) begin
      push_esc(body_mem[i]);
      c = c ^ body_mem[i];
    end
    push_esc(c);
    exp_q.push_back(8'h03);
  endtask

  // pat 0: ready always high; pat 1: ready 1,0,0 repeating. stop_after>0 leaves mid-frame.
  task automatic run_frame(input string tag, input int pat, input int stop_after, input int mid_start_cyc);
    bit         prev_stall;
    logic [7:0] prev_byte;
    int         cyc;
    got.delete();
    done_seen = 0; max_sel = 0; stall_bad = 0; frame_cycles = 0; etx_seen = 1'b0;
    prev_stall = 1'b0; prev_byte = 8'h00;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_start_valid"}, 32'(tx_valid), 32'd1);
    check({tag, "_start_stx"}, 32'(tx_data), 32'h02);
    check({tag, "_start_busy"}, 32'(busy), 32'd1);
    for (cyc = 0; cyc < 400 && !etx_seen; cyc++) begin
      if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_byte)) stall_bad++;
      if (done) done_seen++;
      if (int'(data_selector) > max_sel) max_sel = int'(data_selector);
      start    = (cyc == mid_start_cyc);
      tx_ready = (pat == 0) ? 1'b1 : ((cyc % 3) == 0);
      prev_stall = tx_valid && !tx_ready;
      prev_byte  = tx_data;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        if (tx_data == 8'h03) begin
          etx_seen     = 1'b1;
          frame_cycles = cyc + 1;
        end
      end
      if (stop_after > 0 && got.size() == stop_after) return;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({tag, "_etx_seen"}, 32'(etx_seen), 32'd1);
    check({tag, "_done_pulse"}, 32'(done), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_valid_after"}, 32'(tx_valid), 32'd0);
    check({tag, "_sel_after"}, 32'(data_selector), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_once"}, 32'(done), 32'd0);
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    check({tag, "_max_sel"}, 32'(max_sel), 32'(PACKET_LEN - 1));
    check({tag, "_no_early_done"}, 32'(done_seen), 32'd0);
  endtask

  task automatic load_plain();
    for (int i = 0; i < 64; i++) body_mem[i] = (i < PACKET_LEN) ? 8'(8'h20 + i) : 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) body_mem[i] = 8'h00;
    #12;
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", 32'(tx_data), 32'h00);
    check("rst_sel", 32'(data_selector), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // Plain frame: 02, 20..3C, checksum 3C, 03 in 32 cycles.
    load_plain();
    build_expected();
    run_frame("plain", 0, 0, -1);
    compare_frame("plain");
    check("plain_total", 32'(got.size()), 32'd32);
    check("plain_cycles", 32'(frame_cycles), 32'd32);
    check("plain_chk", 32'(got[30]), 32'h3C);

    // Body escape at index 5: checksum becomes 1A, frame 33 bytes.
    body_mem[5] = 8'h03;
    build_expected();
    run_frame("besc", 0, 0, -1);
    compare_frame("besc");
    check("besc_total", 32'(got.size()), 32'd33);
    check("besc_cycles", 32'(frame_cycles), 32'd33);
    check("besc_pre", 32'(got[5]), 32'h24);
    check("besc_esc", 32'(got[6]), 32'h1B);
    check("besc_sub", 32'(got[7]), 32'h83);
    check("besc_post", 32'(got[8]), 32'h26);
    check("besc_chk", 32'(got[31]), 32'h1A);

    // Checksum escape: 0E ^ 08 = 06 goes out as 1B 86.
    for (int i = 0; i < 64; i++) body_mem[i] = 8'h00;
    body_mem[0] = 8'h0E;
    body_mem[1] = 8'h08;
    build_expected();
    run_frame("cesc", 0, 0, -1);
    compare_frame("cesc");
    check("cesc_total", 32'(got.size()), 32'd33);
    check("cesc_b1", 32'(got[1]), 32'h0E);
    check("cesc_b2", 32'(got[2]), 32'h08);
    check("cesc_esc", 32'(got[30]), 32'h1B);
    check("cesc_sub", 32'(got[31]), 32'h86);
    check("cesc_etx", 32'(got[32]), 32'h03);

    // Backpressure: ready 1,0,0 repeating gives the same plain stream.
    load_plain();
    build_expected();
    run_frame("bp", 1, 0, -1);
    compare_frame("bp");
    check("bp_stall_stable", 32'(stall_bad), 32'd0);
    check("bp_cycles", 32'(frame_cycles), 32'd94);
    tx_ready = 1'b1;

    // Mid-frame start ignored, then reset after 10 bytes.
    run_frame("mid", 0, 10, 5);
    check("mid_len", 32'(got.size()), 32'd10);
    for (int i = 0; i < 10 && i < got.size(); i++)
      check($sformatf("mid_byte%0d", i), 32'(got[i]), 32'(exp_q[i]));
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", 32'(tx_valid), 32'd0);
    check("rstmid_sel", 32'(data_selector), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_data", 32'(tx_data), 32'h00);
    #3;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rstmid_no_resume", 32'(tx_valid), 32'd0);
    run_frame("fresh", 0, 0, -1);
    compare_frame("fresh");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
